led_pwm_periph: RTL and testbench
=================================

# led_pwm_periph

Memory-mapped LED peripheral on the CPU data bus inside `top`. It decodes word stores and loads from the core's load/store unit. It drives the on-board RGB LED with three 8-bit PWM channels and drives the single user LED. It is the consumer of the core's MMIO traffic and the producer of the `RGB_R/G/B` and `LED` pins.

## Interface
Parameters:
- `BASE_ADDR`, `32'hFFFF_0000`: peripheral base. Decoded on `addr[31:8]`.
- `PRESCALE_RST`, `16'd46`: reset value of PRESCALE.
- `BLINK_DIV`, `8'd45`: PWM periods per blink toggle.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: byte address.
- `wdata` in 32: store data.
- `wmask` in 4: byte enables for stores.
- `we` in 1: store strobe, single cycle.
- `re` in 1: load strobe, single cycle.
- `rdata` out 32: load data.
- `rvalid` out 1: load data valid.
- `RGB_R`, `RGB_G`, `RGB_B` out 1: active-low LED drives.
- `LED` out 1: active-high user LED.

## Operation
Registers, by word offset:
- 0x00 CTRL: [0] EN, [1] BLINK.
- 0x04 DUTY_R [7:0].
- 0x08 DUTY_G [7:0].
- 0x0C DUTY_B [7:0].
- 0x10 LEDREG [0].
- 0x14 PRESCALE [15:0].
- 0x18 PWMCNT [7:0], read-only.

Bus behaviour:
- Writes honour `wmask` per byte. Unimplemented bits read 0.
- Unmapped offsets: reads return 0, writes are ignored. Out-of-base addresses are ignored entirely, with no `rvalid`.

PWM datapath:
- Prescaler `pre_cnt` counts 0..PRESCALE. When `pre_cnt >= PRESCALE` it emits `tick` and restarts at 0.
- On `tick`, 8-bit `pwm_cnt` increments and wraps 255→0.
- Each channel has a shadow duty (the register) and an active duty. Active duty loads from shadow only when `tick` causes `pwm_cnt` to wrap to 0.
- Channel on ⇔ `EN && pwm_cnt < active_duty`. Pin = ~on.
  - Duty 0 is never lit.
  - Duty 255 is lit 255/256.
- EN=0: `pre_cnt` and `pwm_cnt` are held at 0, and active duty follows shadow every cycle. All RGB pins read 1.
- Setting EN 0→1 starts a period at `pwm_cnt`=0 with the current duties.

LED output:
- `LED` = LEDREG[0], unless BLINK is active (see Configuration).

## Timing
- Reset values:
  - RGB_R/G/B = 1, LED = 0, rdata = 0, rvalid = 0.
  - CTRL, duties and LEDREG = 0.
  - PRESCALE = PRESCALE_RST.
  - Counters = 0, blink phase = 0.
- A write on cycle N is visible in registers and in reads issued on cycle N+1.
- A read on cycle N gives `rdata` and `rvalid`=1 on cycle N+1. `rvalid` is a one-cycle pulse. `rdata` holds its value until the next read.
- `we` and `re` in the same cycle to the same register: the write completes, and the read returns the pre-write value.
- Tick period is PRESCALE+1 cycles. PWM period is 256·(PRESCALE+1) cycles. PRESCALE=0 gives a tick every cycle.
- Lowering PRESCALE below the current `pre_cnt` produces a tick on the next cycle.
- Pins are registered and lag `pwm_cnt` compare by one cycle.
- `rst` asserted mid-period returns all state to reset values at the next edge.

## Configuration
Macro: `LED_PWM_BLINK_EN`.

Defined:
- An 8-bit counter counts PWM wraps. On reaching BLINK_DIV-1 with CTRL[1]=1 and EN=1, it clears and toggles `blink_phase`.
- While CTRL[1]=1, `LED` = `blink_phase`.
- Clearing CTRL[1] zeroes the counter and the phase.

Undefined:
- CTRL[1] is not stored and reads 0.
- `LED` = LEDREG[0] always.
- No blink logic is synthesised.

## Structure
- Package `led_pwm_pkg` holds:
  - Register offset localparams (`OFF_CTRL` … `OFF_PWMCNT`).
  - CTRL bit indices.
  - Duty width constant `PWM_W = 8`.
  - Reset constants.
- Sub-module `pwm_channel`, instantiated three times. Inputs: `clk`, `rst`, `en`, `wrap`, `shadow_duty`, `pwm_cnt`. Output: registered active-low `pin`. It contains the shadow-to-active load and the compare.

## Test plan
- Reset: hold `rst` 2 cycles, then read all offsets. Expect RGB pins = 1, LED = 0, PRESCALE reads 46, all others read 0, and `rvalid` exactly one cycle after each `re`.
- PWM duty: PRESCALE=0, DUTY_R=64, EN=1. Expect RGB_R low for exactly 64 of each 256 cycles and RGB_G/B stuck high. Repeat with duty 0 (never low) and duty 255 (low 255/256).
- Shadow: mid-period at `pwm_cnt`=100, write DUTY_G=200. Expect the current period unchanged and the new 200-cycle low time from the next `pwm_cnt`=0.
- Byte mask: write 0xAABBCC01 to CTRL with `wmask`=4'b0001 → EN=1, read 0x1. Write to offset 0x40 → no register change, read 0.
- Same-cycle access: `we`+`re` on DUTY_B (old value 5, new value 9). Expect `rdata`=5, then a following read gives 9. Assert `rst` mid-period → pins high on the next cycle.
- With `LED_PWM_BLINK_EN`: PRESCALE=0, BLINK_DIV=2, CTRL=3. Expect `LED` to toggle every 512 cycles. Without the macro, CTRL reads 1 and `LED` follows LEDREG.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM peripheral: register map, CTRL bit
// positions, datapath width and reset values.
package led_pwm_pkg;

  localparam int PWM_W = 8;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_DUTY_R   = 8'h04;
  localparam logic [7:0] OFF_DUTY_G   = 8'h08;
  localparam logic [7:0] OFF_DUTY_B   = 8'h0C;
  localparam logic [7:0] OFF_LEDREG   = 8'h10;
  localparam logic [7:0] OFF_PRESCALE = 8'h14;
  localparam logic [7:0] OFF_PWMCNT   = 8'h18;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;

  localparam logic [1:0]       CTRL_RST  = 2'b00;
  localparam logic [PWM_W-1:0] DUTY_RST  = 8'h00;
  localparam logic             LED_RST   = 1'b0;
  localparam logic [15:0]      CNT16_RST = 16'h0000;
  localparam logic [PWM_W-1:0] CNT8_RST  = 8'h00;

  // Byte-lane merge used for every masked store.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_v,
                                            input logic [7:0] new_v,
                                            input logic       lane_en);
    logic [7:0] res;
    if (lane_en) begin
      res = new_v;
    end else begin
      res = old_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_periph_pwm_channel.sv
// One PWM channel: shadow-to-active duty transfer and registered,
// active-low compare output.
module pwm_channel
  import led_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap,
  input  logic [PWM_W-1:0] shadow_duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             pin
);

  logic [PWM_W-1:0] active_q, active_d;
  logic             pin_q, pin_d;

  // Active duty tracks the shadow while disabled, otherwise only at period wrap.
  always_comb begin
    active_d = active_q;
    if (!en || wrap) begin
      active_d = shadow_duty;
    end else begin
      active_d = active_q;
    end
    pin_d = ~(en && (pwm_cnt < active_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= DUTY_RST;
      pin_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      pin_q    <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule

// File: rtl/led_pwm_periph.sv
// Memory-mapped RGB PWM + user LED peripheral.
// Optional blink feature enabled by defining LED_PWM_BLINK_EN.
module led_pwm_periph
  import led_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter logic [15:0] PRESCALE_RST = 16'd46,
  parameter logic [7:0]  BLINK_DIV    = 8'd45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B,
  output logic        LED
);

`ifdef LED_PWM_BLINK_EN
  localparam logic [1:0] CTRL_WMASK = 2'b11;
`else
  localparam logic [1:0] CTRL_WMASK = 2'b01;
`endif

  logic [1:0]       ctrl_q, ctrl_d;
  logic [PWM_W-1:0] duty_r_q, duty_r_d;
  logic [PWM_W-1:0] duty_g_q, duty_g_d;
  logic [PWM_W-1:0] duty_b_q, duty_b_d;
  logic             ledreg_q, ledreg_d;
  logic [15:0]      prescale_q, prescale_d;
  logic [15:0]      pre_cnt_q, pre_cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             led_out_q, led_out_d;

  logic        hit_s, wr_s, rd_s, en_s, tick_s, wrap_s;
  logic [7:0]  word_off_s;
  logic [31:0] rd_word_s;

  assign hit_s      = (addr[31:8] == BASE_ADDR[31:8]);
  assign word_off_s = {addr[7:2], 2'b00};
  assign wr_s       = we && hit_s;
  assign rd_s       = re && hit_s;
  assign en_s       = ctrl_q[CTRL_EN];

  // Register file store path.
  always_comb begin
    ctrl_d     = ctrl_q;
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    ledreg_d   = ledreg_q;
    prescale_d = prescale_q;
    if (wr_s) begin
      case (word_off_s)
        OFF_CTRL: begin
          if (wmask[0]) begin
            ctrl_d = wdata[1:0] & CTRL_WMASK;
          end else begin
            ctrl_d = ctrl_q;
          end
        end
        OFF_DUTY_R: duty_r_d = byte_merge(duty_r_q, wdata[7:0], wmask[0]);
        OFF_DUTY_G: duty_g_d = byte_merge(duty_g_q, wdata[7:0], wmask[0]);
        OFF_DUTY_B: duty_b_d = byte_merge(duty_b_q, wdata[7:0], wmask[0]);
        OFF_LEDREG: begin
          if (wmask[0]) begin
            ledreg_d = wdata[0];
          end else begin
            ledreg_d = ledreg_q;
          end
        end
        OFF_PRESCALE: prescale_d = {byte_merge(prescale_q[15:8], wdata[15:8], wmask[1]),
                                    byte_merge(prescale_q[7:0], wdata[7:0], wmask[0])};
        default: ctrl_d = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Load path samples pre-write state, so a same-cycle store is not visible.
  always_comb begin
    case (word_off_s)
      OFF_CTRL:     rd_word_s = {30'h0, ctrl_q};
      OFF_DUTY_R:   rd_word_s = {24'h0, duty_r_q};
      OFF_DUTY_G:   rd_word_s = {24'h0, duty_g_q};
      OFF_DUTY_B:   rd_word_s = {24'h0, duty_b_q};
      OFF_LEDREG:   rd_word_s = {31'h0, ledreg_q};
      OFF_PRESCALE: rd_word_s = {16'h0, prescale_q};
      OFF_PWMCNT:   rd_word_s = {24'h0, pwm_cnt_q};
      default:      rd_word_s = 32'h0;
    endcase
    rvalid_d = rd_s;
    if (rd_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Prescaler and PWM counter; >= lets a lowered PRESCALE tick immediately.
  always_comb begin
    tick_s = en_s && (pre_cnt_q >= prescale_q);
    wrap_s = tick_s && (pwm_cnt_q == 8'hFF);
    if (!en_s) begin
      pre_cnt_d = CNT16_RST;
      pwm_cnt_d = CNT8_RST;
    end else if (tick_s) begin
      pre_cnt_d = CNT16_RST;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pre_cnt_d = pre_cnt_q + 16'd1;
      pwm_cnt_d = pwm_cnt_q;
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_phase_q, blink_phase_d;

  // Blink phase advances once every BLINK_DIV PWM periods.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!ctrl_q[CTRL_BLINK]) begin
      blink_cnt_d   = 8'h00;
      blink_phase_d = 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_q == (BLINK_DIV - 8'd1)) begin
        blink_cnt_d   = 8'h00;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
    if (ctrl_d[CTRL_BLINK]) begin
      led_out_d = blink_phase_d;
    end else begin
      led_out_d = ledreg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= 8'h00;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{BLINK_DIV, 1'b0};
  assign led_out_d   = ledreg_d;
`endif

  logic unused_bus_bits;
  assign unused_bus_bits = ^{wdata[31:16], wmask[3:2], addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_RST;
      duty_r_q   <= DUTY_RST;
      duty_g_q   <= DUTY_RST;
      duty_b_q   <= DUTY_RST;
      ledreg_q   <= LED_RST;
      prescale_q <= PRESCALE_RST;
      pre_cnt_q  <= CNT16_RST;
      pwm_cnt_q  <= CNT8_RST;
      rdata_q    <= 32'h0;
      rvalid_q   <= 1'b0;
      led_out_q  <= LED_RST;
    end else begin
      ctrl_q     <= ctrl_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      ledreg_q   <= ledreg_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      led_out_q  <= led_out_d;
    end
  end

  pwm_channel u_ch_r (
    .clk(clk), .rst(rst), .en(en_s), .wrap(wrap_s),
    .shadow_duty(duty_r_q), .pwm_cnt(pwm_cnt_q), .pin(RGB_R)
  );

  pwm_channel u_ch_g (
    .clk(clk), .rst(rst), .en(en_s), .wrap(wrap_s),
    .shadow_duty(duty_g_q), .pwm_cnt(pwm_cnt_q), .pin(RGB_G)
  );

  pwm_channel u_ch_b (
    .clk(clk), .rst(rst), .en(en_s), .wrap(wrap_s),
    .shadow_duty(duty_b_q), .pwm_cnt(pwm_cnt_q), .pin(RGB_B)
  );

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign LED    = led_out_q;

endmodule

// File: tb/tb_led_pwm_periph.sv
// Directed + randomized bench for led_pwm_periph; expected values come
// from duty arithmetic and a register-map scoreboard.
module tb_led_pwm_periph;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst, we, re, rvalid, rgb_r, rgb_g, rgb_b, led;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [0:8];
  logic [31:0] rd_d;
  logic        rd_v, prev_led;
  int          lr, lg, lb, p, dr, dg, db, ntog, t_first, intv;

  always #5 clk = ~clk;

  led_pwm_periph #(.BASE_ADDR(BASE), .PRESCALE_RST(16'd46), .BLINK_DIV(8'd2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
    .we(we), .re(re), .rdata(rdata), .rvalid(rvalid),
    .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b), .LED(led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {31'h0, obs}, {31'h0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_raw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    wr_raw(BASE | {24'h0, off}, d, 4'hF);
  endtask

  task automatic rd_raw(input logic [31:0] a, output logic [31:0] d, output logic v);
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic v;
    rd_raw(BASE | {24'h0, off}, d, v);
    check1({tag, " rvalid"}, v, 1'b1);
    check(tag, d, exp);
    step();
    check1({tag, " rvalid pulse"}, rvalid, 1'b0);
    check({tag, " rdata hold"}, rdata, exp);
  endtask

  task automatic measure(input int n, output int nr, output int ng, output int nb);
    nr = 0; ng = 0; nb = 0;
    repeat (n) begin
      step();
      if (rgb_r == 1'b0) nr++;
      if (rgb_g == 1'b0) ng++;
      if (rgb_b == 1'b0) nb++;
    end
  endtask

  // Program duties with PWM stopped, then start and measure one full period.
  task automatic pwm_run(input int pre, input int r, input int g, input int b, input string tag);
    wr(8'h00, 32'h0);
    wr(8'h14, pre);
    wr(8'h04, r);
    wr(8'h08, g);
    wr(8'h0C, b);
    wr(8'h00, 32'h1);
    step(); step();
    measure(256 * (pre + 1), lr, lg, lb);
    check({tag, " R low"}, lr, r * (pre + 1));
    check({tag, " G low"}, lg, g * (pre + 1));
    check({tag, " B low"}, lb, b * (pre + 1));
  endtask

  function automatic logic [31:0] fmask(input int idx);
    case (idx)
`ifdef LED_PWM_BLINK_EN
      0: return 32'h3;
`else
      0: return 32'h1;
`endif
      1, 2, 3: return 32'hFF;
      4: return 32'h1;
      5: return 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0; wmask = 4'h0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check1("rst RGB_R", rgb_r, 1'b1);
    check1("rst RGB_G", rgb_g, 1'b1);
    check1("rst RGB_B", rgb_b, 1'b1);
    check1("rst LED", led, 1'b0);
    check("rst rdata", rdata, 32'h0);
    check1("rst rvalid", rvalid, 1'b0);
    rd_check("rst CTRL", 8'h00, 32'h0);
    rd_check("rst DUTY_R", 8'h04, 32'h0);
    rd_check("rst DUTY_G", 8'h08, 32'h0);
    rd_check("rst DUTY_B", 8'h0C, 32'h0);
    rd_check("rst LEDREG", 8'h10, 32'h0);
    rd_check("rst PRESCALE", 8'h14, 32'd46);
    rd_check("rst PWMCNT", 8'h18, 32'h0);
    rd_raw(32'h1234_0014, rd_d, rd_v);
    check1("out-of-base read rvalid", rd_v, 1'b0);

    // Duty boundaries at PRESCALE=0
    pwm_run(0, 64, 0, 0, "duty64");
    wr(8'h00, 32'h0);
    step();
    check("disabled pins", {29'h0, rgb_r, rgb_g, rgb_b}, 32'h7);
    pwm_run(0, 0, 0, 0, "duty0");
    pwm_run(0, 255, 0, 0, "duty255");

    // Random duties and prescale
    for (int i = 0; i < 3; i++) begin
      p  = $urandom_range(0, 2);
      dr = $urandom_range(0, 255);
      dg = $urandom_range(0, 255);
      db = $urandom_range(0, 255);
      pwm_run(p, dr, dg, db, "rand");
    end

    // Shadow duty: change mid-period takes effect at the next period
    wr(8'h00, 32'h0);
    wr(8'h14, 32'h0);
    wr(8'h04, 32'h0);
    wr(8'h0C, 32'h0);
    wr(8'h08, 32'd50);
    wr(8'h00, 32'h1);
    measure(100, lr, lg, lb);
    check("shadow first part G", lg, 50);
    wr(8'h08, 32'd200);
    check1("shadow at cnt100 G", rgb_g, 1'b1);
    measure(155, lr, lg, lb);
    check("shadow rest of period G", lg, 0);
    measure(256, lr, lg, lb);
    check("shadow next period G", lg, 200);

    // Lowering PRESCALE below pre_cnt ticks on the next cycle
    wr(8'h00, 32'h0);
    wr(8'h14, 32'd200);
    wr(8'h00, 32'h1);
    repeat (50) step();
    wr(8'h14, 32'd10);
    step();
    rd_check("prescale lowered PWMCNT", 8'h18, 32'h1);

    // Byte masks and decode
    wr(8'h00, 32'h0);
    wr_raw(BASE, 32'hAABB_CC01, 4'b0001);
    rd_check("masked CTRL", 8'h00, 32'h1);
    wr_raw(BASE | 32'h4, 32'h1234_5678, 4'b0000);
    rd_check("mask0 DUTY_R", 8'h04, 32'h0);
    wr_raw(BASE | 32'h14, 32'hFFFF_ABCD, 4'b0010);
    rd_check("upper byte PRESCALE", 8'h14, 32'hAB0A);
    wr_raw(BASE | 32'h40, 32'hFFFF_FFFF, 4'hF);
    rd_check("unmapped 0x40", 8'h40, 32'h0);
    rd_check("unmapped keeps DUTY_G", 8'h08, 32'd200);
    wr_raw(32'h0000_0004, 32'h77, 4'hF);
    rd_check("out-of-base write", 8'h04, 32'h0);

    // Same-cycle store and load
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'd5);
    addr = BASE | 32'h0C; wdata = 32'd9; wmask = 4'hF; we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    check1("same-cycle rvalid", rvalid, 1'b1);
    check("same-cycle old value", rdata, 32'd5);
    step();
    rd_check("same-cycle new value", 8'h0C, 32'd9);

    // Mid-period reset
    wr(8'h14, 32'h0);
    wr(8'h04, 32'd128);
    wr(8'h10, 32'h1);
    wr(8'h00, 32'h1);
    repeat (10) step();
    check1("pre-reset RGB_R lit", rgb_r, 1'b0);
    check1("pre-reset LED", led, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post-reset pins", {29'h0, rgb_r, rgb_g, rgb_b}, 32'h7);
    check1("post-reset LED", led, 1'b0);
    rd_check("post-reset CTRL", 8'h00, 32'h0);
    rd_check("post-reset PRESCALE", 8'h14, 32'd46);

    // User LED and blink
    wr(8'h10, 32'h1);
    check1("LED follows LEDREG=1", led, 1'b1);
`ifdef LED_PWM_BLINK_EN
    wr(8'h10, 32'h0);
    wr(8'h14, 32'h0);
    wr(8'h00, 32'h3);
    rd_check("blink CTRL", 8'h00, 32'h3);
    ntog = 0; t_first = 0; intv = 0;
    prev_led = led;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (led !== prev_led) begin
        ntog++;
        if (ntog == 1) t_first = i;
        if (ntog == 2) intv = i - t_first;
        prev_led = led;
      end
    end
    check("blink toggle count", ntog, 2);
    check("blink interval", intv, 512);
    wr(8'h10, 32'h1);
    wr(8'h00, 32'h1);
    check1("blink off LED=LEDREG", led, 1'b1);
    wr(8'h10, 32'h0);
    wr(8'h00, 32'h3);
    check1("blink restart phase 0", led, 1'b0);
`else
    wr(8'h00, 32'h3);
    rd_check("no-blink CTRL", 8'h00, 32'h1);
    check1("no-blink LED", led, 1'b1);
    wr(8'h10, 32'h0);
    check1("LED follows LEDREG=0", led, 1'b0);
`endif

    // Randomized register scoreboard with PWM kept stopped
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) mdl[k] = 32'h0;
    mdl[5] = 32'd46;
    for (int i = 0; i < 24; i++) begin
      int idx;
      logic [31:0] d;
      logic [3:0]  m;
      idx = $urandom_range(0, 8);
      d   = $urandom;
      m   = 4'($urandom_range(0, 15));
      if (idx == 0) d[0] = 1'b0;
      wr_raw(BASE | (idx * 4), d, m);
      for (int b = 0; b < 4; b++) begin
        if (m[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      mdl[idx] = mdl[idx] & fmask(idx);
      rd_check("scoreboard", 8'(idx * 4), mdl[idx]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
